// File: rtl/bit_stream_pkg.sv
// Shared types, defaults and helpers for the serial frame checker family.
package bit_stream_pkg;

  localparam int DEF_FRAME_LEN = 3;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } state_t;

  // Operands are zero-extended by the caller; unused upper bits have mask 0.
  function automatic logic masked_match(input logic [31:0] frame,
                                        input logic [31:0] pattern,
                                        input logic [31:0] mask);
    return ((frame ^ pattern) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/bit_stream_checker_if.sv
// Serial input, run-time configuration and error status of the frame checker.
interface bit_stream_checker_if #(
  parameter int FRAME_LEN = 3,
  parameter int CNT_W     = 8
);
  logic                 din;
  logic                 din_vld;
  logic                 sync;
  logic [FRAME_LEN-1:0] pattern;
  logic [FRAME_LEN-1:0] mask;
  logic                 clr;
  logic                 err;
  logic                 frame_done;
  logic                 err_sticky;
  logic [CNT_W-1:0]     err_cnt;

  modport master (
    output din, din_vld, sync, pattern, mask, clr,
    input  err, frame_done, err_sticky, err_cnt
  );

  modport slave (
    input  din, din_vld, sync, pattern, mask, clr,
    output err, frame_done, err_sticky, err_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins, then the event applies.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = inc ? W'(1) : '0;
    end else if (inc && (cnt_reg != MAX)) begin
      cnt_next = cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/bit_stream_checker.sv
// Collects FRAME_LEN qualified serial bits and flags frames matching a masked pattern.
module bit_stream_checker
  import bit_stream_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  bit_stream_checker_if.slave bus
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int SH_W  = FRAME_LEN - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 2);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [SH_W-1:0]      sh_reg, sh_next;
  logic                 err_reg, err_next;
  logic                 done_reg, done_next;
  logic                 sticky_reg, sticky_next;
  logic [FRAME_LEN-1:0] frame;
  logic                 accept;
  logic                 complete;
  logic                 match;

  // sync outranks din_vld, so a bit arriving with sync is never accepted.
  assign accept   = bus.din_vld && !bus.sync;
  assign complete = accept && (state_reg == LAST);
  assign frame    = {sh_reg, bus.din};
  assign match    = masked_match(32'(frame), 32'(bus.pattern), 32'(bus.mask));

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    sh_next     = sh_reg;
    done_next   = complete;
    err_next    = complete && match;
    sticky_next = bus.clr ? err_next : (sticky_reg | err_next);

    if (bus.sync) begin
      state_next = COLLECT;
      idx_next   = '0;
      sh_next    = '0;
    end else if (bus.din_vld) begin
      // Truncating the concatenation keeps the newest SH_W bits, also for SH_W == 1.
      sh_next = SH_W'({sh_reg, bus.din});
      case (state_reg)
        COLLECT: begin
          idx_next = idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            state_next = LAST;
          end
        end
        LAST: begin
          idx_next   = '0;
          state_next = COLLECT;
        end
        default: begin
          idx_next   = '0;
          state_next = COLLECT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= COLLECT;
      idx_reg    <= '0;
      sh_reg     <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      sticky_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      sh_reg     <= sh_next;
      err_reg    <= err_next;
      done_reg   <= done_next;
      sticky_reg <= sticky_next;
    end
  end

  // Counting the registered-to-be err keeps err, err_sticky and err_cnt aligned.
  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_next),
    .clr (bus.clr),
    .cnt (bus.err_cnt)
  );

  assign bus.err        = err_reg;
  assign bus.frame_done = done_reg;
  assign bus.err_sticky = sticky_reg;

endmodule

// File: tb/tb_bit_stream_checker.sv
// Directed checks of bit_stream_checker in three configurations.
module tb_bit_stream_checker;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bit_stream_checker_if #(.FRAME_LEN(3), .CNT_W(8)) ia ();
  bit_stream_checker_if #(.FRAME_LEN(5), .CNT_W(8)) ib ();
  bit_stream_checker_if #(.FRAME_LEN(3), .CNT_W(2)) ic ();

  bit_stream_checker #(.FRAME_LEN(3), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(ia));
  bit_stream_checker #(.FRAME_LEN(5), .CNT_W(8)) u_b (.clk(clk), .rst(rst), .bus(ib));
  bit_stream_checker #(.FRAME_LEN(3), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .bus(ic));

  // The narrow-counter instance sees exactly the default instance's stimulus.
  assign ic.din     = ia.din;
  assign ic.din_vld = ia.din_vld;
  assign ic.sync    = ia.sync;
  assign ic.clr     = ia.clr;
  assign ic.pattern = ia.pattern;
  assign ic.mask    = ia.mask;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_step(input logic v, input logic d, input logic s, input logic c);
    ia.din_vld = v;
    ia.din     = d;
    ia.sync    = s;
    ia.clr     = c;
    ib.din_vld = 1'b0;
    cyc();
    ia.din_vld = 1'b0;
    ia.sync    = 1'b0;
    ia.clr     = 1'b0;
  endtask

  task automatic b_step(input logic d);
    ia.din_vld = 1'b0;
    ib.din_vld = 1'b1;
    ib.din     = d;
    cyc();
    ib.din_vld = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    ia.din     = 1'b0;
    ia.din_vld = 1'b0;
    ia.sync    = 1'b0;
    ia.clr     = 1'b0;
    ia.pattern = 3'b111;
    ia.mask    = 3'b111;
    ib.din     = 1'b0;
    ib.din_vld = 1'b0;
    ib.sync    = 1'b0;
    ib.clr     = 1'b0;
    ib.pattern = 5'b10100;
    ib.mask    = 5'b11100;

    #1;
    chk("rst_err", 32'(ia.err), 0);
    chk("rst_done", 32'(ia.frame_done), 0);
    chk("rst_sticky", 32'(ia.err_sticky), 0);
    chk("rst_cnt", 32'(ia.err_cnt), 0);
    repeat (2) cyc();
    rst = 1'b1;

    // Legacy behaviour: 111 is an error frame, 110 is not.
    a_step(1, 1, 0, 0); chk("t1_b1_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0); chk("t1_b2_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0);
    chk("t1_f1_err", 32'(ia.err), 1);
    chk("t1_f1_done", 32'(ia.frame_done), 1);
    chk("t1_f1_cnt", 32'(ia.err_cnt), 1);
    chk("t1_f1_sticky", 32'(ia.err_sticky), 1);
    a_step(1, 1, 0, 0);
    chk("t1_pulse_err", 32'(ia.err), 0);
    chk("t1_pulse_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0);
    a_step(1, 0, 0, 0);
    chk("t1_f2_err", 32'(ia.err), 0);
    chk("t1_f2_done", 32'(ia.frame_done), 1);
    chk("t1_f2_cnt", 32'(ia.err_cnt), 1);

    // Five-bit frames with a partial mask: 10111 matches, 00100 does not.
    b_step(1); b_step(0); b_step(1); b_step(1);
    chk("t2_f1_early", 32'(ib.frame_done), 0);
    b_step(1);
    chk("t2_f1_err", 32'(ib.err), 1);
    chk("t2_f1_done", 32'(ib.frame_done), 1);
    b_step(0); b_step(0); b_step(1); b_step(0); b_step(0);
    chk("t2_f2_err", 32'(ib.err), 0);
    chk("t2_f2_done", 32'(ib.frame_done), 1);
    chk("t2_cnt", 32'(ib.err_cnt), 1);

    // sync in LAST discards the frame; the bit presented with sync is dropped.
    a_step(1, 1, 0, 0); a_step(1, 1, 0, 0);
    a_step(1, 1, 1, 0); chk("t3_sync_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0); chk("t3_post_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0);
    chk("t3_b2_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0);
    chk("t3_err", 32'(ia.err), 1);
    chk("t3_cnt", 32'(ia.err_cnt), 2);

    // Same again with din_vld gaps inside the frame.
    a_step(1, 0, 0, 0); a_step(1, 0, 1, 0);
    a_step(1, 1, 0, 0); a_step(0, 0, 0, 0);
    a_step(1, 1, 0, 0); a_step(0, 1, 0, 0); a_step(0, 1, 0, 0);
    chk("t3g_gap_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0);
    chk("t3g_err", 32'(ia.err), 1);
    chk("t3g_done", 32'(ia.frame_done), 1);
    chk("t3g_cnt", 32'(ia.err_cnt), 3);
    chk("t3g_cnt_c", 32'(ic.err_cnt), 3);

    // Clear, then saturate the 2-bit counter.
    a_step(0, 0, 0, 1);
    chk("t4_clr_cnt", 32'(ia.err_cnt), 0);
    chk("t4_clr_sticky", 32'(ia.err_sticky), 0);
    chk("t4_clr_cnt_c", 32'(ic.err_cnt), 0);
    for (int k = 1; k <= 5; k++) begin
      a_step(1, 1, 0, 0); a_step(1, 1, 0, 0); a_step(1, 1, 0, 0);
      chk($sformatf("t4_err_%0d", k), 32'(ic.err), 1);
      chk($sformatf("t4_cnt_c_%0d", k), 32'(ic.err_cnt), (k < 3) ? k : 3);
      chk($sformatf("t4_cnt_a_%0d", k), 32'(ia.err_cnt), k);
    end

    // clr coinciding with the third error's increment.
    a_step(0, 0, 0, 1);
    for (int k = 1; k <= 2; k++) begin
      a_step(1, 1, 0, 0); a_step(1, 1, 0, 0); a_step(1, 1, 0, 0);
    end
    chk("t5_pre_cnt", 32'(ia.err_cnt), 2);
    a_step(1, 1, 0, 0); a_step(1, 1, 0, 0); a_step(1, 1, 0, 1);
    chk("t5_err", 32'(ia.err), 1);
    chk("t5_cnt", 32'(ia.err_cnt), 1);
    chk("t5_sticky", 32'(ia.err_sticky), 1);
    chk("t5_cnt_c", 32'(ic.err_cnt), 1);

    // Asynchronous reset mid-frame discards the two collected bits.
    a_step(1, 1, 0, 0); a_step(1, 1, 0, 0);
    rst = 1'b0;
    #1;
    chk("t6_rst_cnt", 32'(ia.err_cnt), 0);
    chk("t6_rst_sticky", 32'(ia.err_sticky), 0);
    chk("t6_rst_done", 32'(ia.frame_done), 0);
    cyc();
    rst = 1'b1;
    a_step(1, 1, 0, 0); chk("t6_b1_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0); chk("t6_b2_done", 32'(ia.frame_done), 0);
    a_step(1, 1, 0, 0);
    chk("t6_err", 32'(ia.err), 1);
    chk("t6_done", 32'(ia.frame_done), 1);
    chk("t6_cnt", 32'(ia.err_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_stream_checker.md
Name: bit_stream_checker

Overview:
- Parametrised serial frame checker; successor to the fixed 3-bit frame error detector.
- Collects FRAME_LEN qualified bits from a serial stream.
- Compares each completed frame against a masked run-time pattern and flags matches as errors.
- Adds input qualification, frame resync, a sticky error flag and a saturating error counter; sits on the serial receive path ahead of the framer/statistics logic.

Parameters:
- FRAME_LEN, 3, bits per frame; legal range 2..32.
- CNT_W, 8, error counter width; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_vld  input  1  din is sampled only when high.
- sync  input  1  frame restart: the current frame is discarded.
- pattern  input  FRAME_LEN  error pattern; bit FRAME_LEN-1 = first bit of the frame.
- mask  input  FRAME_LEN  1 = compare this position, 0 = don't care.
- clr  input  1  synchronous clear of err_sticky and err_cnt.
- err  output  1  one-cycle pulse, registered, for each matching frame.
- frame_done  output  1  one-cycle pulse, registered, at the end of every frame.
- err_sticky  output  1  set on any err; held until clr.
- err_cnt  output  CNT_W  saturating count of error frames.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, bit index 0, shift register 0, FSM in COLLECT.
  - Any frame in progress is discarded.
  - After release, the first valid bit is bit 0 of a new frame.
- FSM states:
  - COLLECT: accepting bits 0..FRAME_LEN-2.
  - LAST: next valid bit completes the frame.
- FSM transitions:
  - COLLECT -> LAST when din_vld and idx == FRAME_LEN-2.
  - LAST -> COLLECT on a valid bit.
  - Any state -> COLLECT on sync.
  - FRAME_LEN == 2 enters LAST after the first bit.
- Bit accept: on din_vld, shift din into the LSB of shift register sh and increment idx.
  - din_vld low: sh, idx and the state all hold; no gaps are counted.
- Frame completion:
  - Completion cycle is a valid bit in LAST.
  - Candidate frame f = {sh[FRAME_LEN-2:0], din}.
  - Match = ((f ^ pattern) & mask) == 0.
  - Next cycle: frame_done = 1; err = match.
  - Latency is exactly 1 clock from the last bit's sampling edge.
- Config sampling: pattern and mask are sampled only in the completion cycle; changes mid-frame are legal.
  - mask all zeros: every frame is an error.
- sync:
  - Has priority over din_vld.
  - On the sync cycle: idx = 0, sh = 0, no completion.
  - The din on that cycle is dropped.
  - Frame counting restarts with the next valid bit.
- err_sticky: set the cycle err asserts; cleared by clr.
- err_cnt:
  - Increments by 1 each time err asserts.
  - Saturates at 2^CNT_W-1; no wrap.
- clr in the same cycle as a new increment: clear first, then apply the event, giving err_cnt = 1 and err_sticky = 1.
- Default configuration (FRAME_LEN = 3, pattern = 111, mask = 111) reproduces the legacy 3-bit "111" frame error check with registered err.

Decomposition:
- Shared package bit_stream_pkg holds:
  - State enum (COLLECT, LAST).
  - Default FRAME_LEN/CNT_W constants.
  - Helper function for the masked compare.
- One natural sub-module: sat_counter (width CNT_W; inc, clr, saturating), reusable by other statistics blocks.
- The FSM and shift register stay in the top module.

Test Plan:
- Defaults, din_vld = 1, stream 1,1,1 then 1,1,0 -> err pulses once 1 clk after the 3rd bit; frame_done pulses twice; err_cnt = 1, err_sticky = 1.
- FRAME_LEN = 5, pattern = 10100, mask = 11100, frames 10111 and 00100 -> err on the first frame only; err_cnt = 1.
- Defaults, bits 1,1 then sync, then 1 -> no frame_done.
  - Then 1,1 -> frame 111 completes; err = 1.
  - din_vld low gaps inserted mid-frame -> identical result.
- CNT_W = 2, five matching frames -> err_cnt goes 1,2,3,3,3; err pulses 5 times.
- clr asserted in the same cycle as the increment for a 3rd error -> err_cnt = 1, err_sticky = 1.
- rst low for 1 clk after 2 bits of a frame, then 1,1,1 -> outputs 0 during reset; err only after the three post-reset bits.
